sevenseg_scan: RTL and testbench
================================

SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 The module SHALL have parameter NUM_DIGITS, default 4, giving the number of multiplexed digits; legal range 1..8.
REQ-002 The module SHALL have parameter DIV, default 50000, giving clk cycles per digit slot; legal range >=1.
REQ-003 The module SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, width 1: reset, asynchronous and active-high.
REQ-005 The module SHALL have port data_in, input, width 4*NUM_DIGITS: hex nibbles, digit k = data_in[4k+3:4k], digit 0 rightmost.
REQ-006 The module SHALL have port load, input, width 1: single-cycle strobe capturing data_in into the shadow register.
REQ-007 The module SHALL have port blank_mask, input, width NUM_DIGITS: bit k=1 forces digit k blank; sampled live.
REQ-008 The module SHALL have port seg, output, width 7: segments {a,b,c,d,e,f,g}, a = bit 6, active-high, registered.
REQ-009 The module SHALL have port an, output, width NUM_DIGITS: one-hot active-high digit enable, registered.
REQ-010 The module SHALL have port pending, output, width 1: shadow holds data not yet shown.
REQ-011 The module SHALL have port frame_tick, output, width 1: one-cycle pulse on each frame boundary.

Function
REQ-012 The prescaler SHALL count 0..DIV-1 and wrap; at DIV-1 the digit index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-013 The frame boundary SHALL be the cycle in which the index wraps to 0; frame_tick SHALL be 1 in exactly that cycle.
REQ-014 On load=1 the shadow SHALL capture data_in and pending SHALL set; a later load before a swap SHALL overwrite (last wins).
REQ-015 At a frame boundary with pending=1, the display register SHALL take the shadow value held before that edge and pending SHALL clear.
REQ-016 If load and a frame boundary coincide, the old shadow SHALL swap, the new data SHALL enter the shadow, and pending SHALL remain 1.
REQ-017 The display register SHALL change only at frame boundaries, so no frame mixes old and new digits.
REQ-018 seg and an SHALL reflect the current index with 1 cycle of latency: an = 1<<index, seg = decode(display nibble[index]).
REQ-019 Decode SHALL map hex digits to seg as follows: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-020 A blanked digit SHALL drive seg=0000000 while an still asserts its bit, keeping scan timing constant.
REQ-021 With DIV=1 the index SHALL advance every cycle; with NUM_DIGITS=1 frame_tick SHALL pulse every DIV cycles.

Reset
REQ-022 While rst=1: prescaler=0, index=0, shadow=0, display=0, pending=0, frame_tick=0, seg=0000000, an=all zero.
REQ-023 On the first clk edge after rst falls, outputs SHALL be an=1<<0 and seg=1111110 (digit 0 of an all-zero display).
REQ-024 rst asserted mid-frame or with pending=1 SHALL discard pending data and the display content immediately.

Configuration
REQ-025 With SEVENSEG_LZB_EN defined, digits above the most significant non-zero display nibble SHALL be blanked in addition to blank_mask; digit 0 SHALL never be LZB-blanked.
REQ-026 Without SEVENSEG_LZB_EN defined, only blank_mask SHALL blank digits and no LZB logic SHALL be synthesised.

Verification (NUM_DIGITS=4, DIV=2)
REQ-027 Release reset -> an scans 0001,0010,0100,1000 every 2 cycles with seg=1111110; frame_tick pulses every 8 cycles.
REQ-028 load data_in=16'h1A3F mid-frame -> pending=1, digits unchanged until next frame_tick, then an=0001 gives seg=1000111 and an=1000 gives seg=0110000, pending=0.
REQ-029 Two loads, 16'h1111 then 16'h2222, in one frame -> only 2222 is displayed (seg=1101101 on all digits).
REQ-030 load coinciding with frame_tick -> the previous shadow is displayed and pending stays 1 for one more frame.
REQ-031 blank_mask=4'b0100 -> while an=0100, seg=0000000; other digits are unaffected.
REQ-032 Display 16'h0050 with SEVENSEG_LZB_EN -> digits 3 and 2 blank, digit 1 = 1011011, digit 0 = 1111110; without the macro, digits 3 and 2 = 1111110.

Source files
------------

// File: rtl/sevenseg_scan.sv
// ---------------------------------------------------------------------------
// sevenseg_scan
//   Time-multiplexed driver for a NUM_DIGITS-digit hex seven-segment display.
//   A prescaler divides clk down to one digit slot every DIV cycles.
//   The digit index steps through 0..NUM_DIGITS-1 one slot at a time.
//   New data is double-buffered: it goes into a shadow register first and
//   moves to the display register only at a frame boundary. A frame therefore
//   never shows a mix of old and new digits.
//
// Parameters
//   NUM_DIGITS  number of multiplexed digits (1..8)
//   DIV         clk cycles per digit slot (>= 1)
//
// Ports
//   clk         clock, all state changes on its rising edge
//   rst         asynchronous active-high reset
//   data_in     hex nibbles, digit k = data_in[4k+3:4k], digit 0 rightmost
//   load        single-cycle strobe capturing data_in into the shadow
//   blank_mask  bit k = 1 blanks digit k (sampled live)
//   seg         registered segments {a,b,c,d,e,f,g}, a = bit 6, active-high
//   an          registered one-hot active-high digit enable
//   pending     shadow holds data that has not been displayed yet
//   frame_tick  one-cycle pulse in the first cycle of every frame
//
// Handshake: load has no ready. Every cycle with load=1 is accepted.
//   A later load overwrites an undisplayed shadow value (last wins).
//
// Build option
//   SEVENSEG_LZB_EN  when defined, leading-zero blanking is added. Digits
//                    above the most significant non-zero display nibble are
//                    blanked. Digit 0 is never blanked this way.
// ---------------------------------------------------------------------------
module sevenseg_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] display;

    logic                    slot_end;
    logic                    frame_end;
    logic [3:0]              cur_nib;
    logic [NUM_DIGITS-1:0]   an_next;
    logic                    blank;

    // Hex digit to {a,b,c,d,e,f,g}
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // The last cycle of the last slot. The edge that ends it is the
    // frame boundary: the index wraps to 0 and a pending shadow is swapped in.
    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Prescaler and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Shadow / display double buffer. When load and a boundary coincide,
    // the old shadow moves to display while the new data enters the shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow     <= '0;
            display    <= '0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (frame_end && pending) begin
                display <= shadow;
            end
            if (load) begin
                shadow  <= data_in;
                pending <= 1'b1;
            end else if (frame_end) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        cur_nib = display[{idx, 2'b00} +: 4];
    end

    always_comb begin
        an_next      = '0;
        an_next[idx] = 1'b1;
    end

`ifdef SEVENSEG_LZB_EN
    // lzb_mask[k] is set when nibbles k..NUM_DIGITS-1 are all zero (k >= 1)
    logic [NUM_DIGITS-1:0] lzb_mask;
    logic                  upper_zero;

    always_comb begin
        lzb_mask   = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero  = upper_zero && (display[4*k +: 4] == 4'h0);
            lzb_mask[k] = upper_zero;
        end
    end

    assign blank = blank_mask[idx] | lzb_mask[idx];
`else
    assign blank = blank_mask[idx];
`endif

    // Outputs register the current index. A blanked digit still gets its
    // an bit, so scan timing does not depend on blanking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= 7'b0000000;
            an  <= '0;
        end else begin
            seg <= blank ? 7'b0000000 : decode(cur_nib);
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan.sv
module tb_sevenseg_scan;

  localparam int N   = 4;
  localparam int DIV = 2;
  localparam int FRAME = N * DIV;

  logic          clk;
  logic          rst;
  logic [4*N-1:0] data_in;
  logic          load;
  logic [N-1:0]  blank_mask;
  logic [6:0]    seg;
  logic [N-1:0]  an;
  logic          pending;
  logic          frame_tick;

  int tests;
  int fails;

  sevenseg_scan #(.NUM_DIGITS(N), .DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load       (load),
    .blank_mask (blank_mask),
    .seg        (seg),
    .an         (an),
    .pending    (pending),
    .frame_tick (frame_tick)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] dec_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int             m_edges;
  logic [4*N-1:0] m_shadow;
  logic [4*N-1:0] m_disp;
  logic           m_pend;
  logic [12:0]    exp_q[$];

  function automatic int msnz(input logic [4*N-1:0] d);
    int r;
    r = 0;
    for (int k = 0; k < N; k++)
      if (d[4*k +: 4] != 4'h0) r = k;
    return r;
  endfunction

  // Edges are counted from reset release. Outputs after edge e show digit
  // ((e-1)/DIV)%N, and frames end on edges that are multiples of N*DIV.
  always @(posedge clk) begin
    logic [6:0] e_seg;
    logic [N-1:0] e_an;
    logic e_ft;
    logic blk;
    int ib;
    if (rst) begin
      m_edges  = 0;
      m_shadow = '0;
      m_disp   = '0;
      m_pend   = 1'b0;
      exp_q.push_back(13'd0);
    end else begin
      m_edges++;
      ib   = ((m_edges - 1) / DIV) % N;
      blk  = blank_mask[ib];
`ifdef SEVENSEG_LZB_EN
      if (ib > msnz(m_disp)) blk = 1'b1;
`endif
      e_seg = blk ? 7'b0 : dec_tab[m_disp[4*ib +: 4]];
      e_an  = '0;
      e_an[ib] = 1'b1;
      e_ft  = (m_edges % FRAME) == 0;
      if (e_ft && m_pend) begin
        m_disp = m_shadow;
        m_pend = 1'b0;
      end
      if (load) begin
        m_shadow = data_in;
        m_pend   = 1'b1;
      end
      exp_q.push_back({e_ft, m_pend, e_an, e_seg});
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(posedge clk) begin
    logic [12:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if ({frame_tick, pending, an, seg} !== e) begin
        fails++;
        $display("FAIL scoreboard t=%0t act ft=%b pend=%b an=%b seg=%b exp ft=%b pend=%b an=%b seg=%b",
                 $time, frame_tick, pending, an, seg, e[12], e[11], e[10:7], e[6:0]);
      end
    end
  end

  // ---------------- driver / directed helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) return;
    end
    tests++;
    fails++;
    $display("FAIL wait_tick timeout");
  endtask

  task automatic wait_an(input logic [N-1:0] t);
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (an === t) return;
    end
    tests++;
    fails++;
    $display("FAIL wait_an timeout an=%b exp=%b", an, t);
  endtask

  task automatic do_load(input logic [4*N-1:0] d);
    data_in = d;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic check_digit(input string name, input logic [N-1:0] a, input logic [6:0] s);
    wait_an(a);
    check(name, seg, s);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    tests      = 0;
    fails      = 0;
    rst        = 1'b1;
    load       = 1'b0;
    data_in    = '0;
    blank_mask = '0;
    repeat (3) @(negedge clk);
    check("rst_seg", seg, 7'b0);
    check("rst_an", an, 4'b0000);
    check("rst_pend", pending, 1'b0);
    check("rst_ft", frame_tick, 1'b0);

    rst = 1'b0;
    @(negedge clk);
    check("rel_an", an, 4'b0001);
    check("rel_seg", seg, 7'b1111110);
    check_digit("scan_d1", 4'b0010, 7'b1111110);
    check_digit("scan_d3", 4'b1000, 7'b1111110);

    // mid-frame load of 1A3F
    do_load(16'h1A3F);
    check("pend_set", pending, 1'b1);
    wait_tick();
    check("pend_clr", pending, 1'b0);
    check_digit("1a3f_d0", 4'b0001, 7'b1000111);
    check_digit("1a3f_d3", 4'b1000, 7'b0110000);

    // two loads in one frame: last wins
    wait_tick();
    do_load(16'h1111);
    do_load(16'h2222);
    wait_tick();
    for (int k = 0; k < N; k++) begin
      logic [N-1:0] a;
      a = '0;
      a[k] = 1'b1;
      check_digit("last_wins", a, 7'b1101101);
    end

    // load coinciding with the frame boundary
    wait_tick();
    data_in = 16'h4444;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    repeat (FRAME - 2) @(negedge clk);
    data_in = 16'h3333;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    check("coin_ft", frame_tick, 1'b1);
    check("coin_pend", pending, 1'b1);
    check_digit("coin_old", 4'b0001, 7'b0110011);
    wait_tick();
    check("coin_pend2", pending, 1'b0);
    check_digit("coin_new", 4'b0001, 7'b1111001);

    // blank_mask on digit 2
    blank_mask = 4'b0100;
    check_digit("bm_d2", 4'b0100, 7'b0000000);
    check_digit("bm_d3", 4'b1000, 7'b1111001);
    check_digit("bm_d0", 4'b0001, 7'b1111001);
    blank_mask = '0;

    // leading-zero case
    wait_tick();
    do_load(16'h0050);
    wait_tick();
`ifdef SEVENSEG_LZB_EN
    check_digit("lzb_d3", 4'b1000, 7'b0000000);
    check_digit("lzb_d2", 4'b0100, 7'b0000000);
`else
    check_digit("lzb_d3", 4'b1000, 7'b1111110);
    check_digit("lzb_d2", 4'b0100, 7'b1111110);
`endif
    check_digit("lzb_d1", 4'b0010, 7'b1011011);
    check_digit("lzb_d0", 4'b0001, 7'b1111110);

    // randomized phase with one mid-run reset
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (i == 700) begin
        rst = 1'b1;
        load = 1'b1;
        data_in = 16'hBEEF;
        repeat (3) @(negedge clk);
        check("midrst_pend", pending, 1'b0);
        check("midrst_an", an, 4'b0000);
        rst = 1'b0;
        load = 1'b0;
      end else begin
        load       = ($urandom_range(0, 5) == 0);
        data_in    = 16'($urandom);
        blank_mask = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      end
    end
    load = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
